// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch front end. Generates sequential word-aligned PCs, issues
//   them to instruction memory over a valid/ready request channel, collects
//   the in-order responses into a small fetch buffer tagged with their PCs,
//   and presents the buffer head to the IF/ID register. A redirect from EX
//   flushes the buffer and restarts fetch at the new target. Responses that
//   were still in flight at the redirect are counted and dropped on arrival.
//
// Parameters
//   WIDTH     data/address width
//   RESET_PC  first fetch address after reset
//   BUF_DEPTH fetch-buffer entries, also the limit on outstanding requests
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   imem_req_*      request channel: valid/ready handshake, word address
//   imem_rsp_*      response channel: one word per valid, in request order
//   redirect_*      control-flow redirect and its target (bits [1:0] ignored)
//   stall           IF/ID holding; the head entry is not consumed
//   if_valid/pc/instr  head of the fetch buffer (0 / NOP when empty)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr
);

  localparam int CW = $clog2(BUF_DEPTH + 1) + 2;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW-1:0]    DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [PW-1:0]    LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(4);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    FETCH    = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] fetch_pc_reg;
  logic [WIDTH-1:0] resp_pc_reg;
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    occ_reg;   // filled buffer entries
  logic [CW-1:0]    live_reg;  // accepted requests whose words will be kept
  logic [CW-1:0]    kill_reg;  // accepted requests whose words must be dropped

  logic [WIDTH-1:0] buf_pc    [BUF_DEPTH];
  logic [WIDTH-1:0] buf_instr [BUF_DEPTH];

  logic             do_pop;
  logic             do_push;
  logic             do_drop;
  logic             req_fire;
  logic [CW-1:0]    occ_after_pop;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    kill_redirect;
  logic [CW-1:0]    kill_next;
  logic [WIDTH-1:0] redirect_aligned;
  logic             unused_redirect_lsbs;

  assign redirect_aligned     = {redirect_pc[WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Head of buffer drives the IF/ID interface directly.
  assign if_valid = (occ_reg != '0);
  assign if_pc    = if_valid ? buf_pc[head_reg]    : '0;
  assign if_instr = if_valid ? buf_instr[head_reg] : NOP;

  // A redirect clears the buffer, so nothing is popped or pushed that cycle.
  assign do_pop  = if_valid & ~stall & ~redirect_valid;
  assign do_drop = imem_rsp_valid & (kill_reg != '0);
  assign do_push = imem_rsp_valid & (kill_reg == '0) & (live_reg != '0) & ~redirect_valid;

  // The head leaving this cycle frees its slot for a new request; this is
  // what lets a 2-entry buffer sustain one instruction per cycle with a
  // 1-cycle memory. Every accepted request still has a guaranteed slot.
  assign occ_after_pop = occ_reg - CW'(do_pop);
  assign outstanding   = live_reg + kill_reg;

  assign imem_req_valid = (state_reg != RST_WAIT) & ~redirect_valid &
                          ((occ_after_pop + live_reg) < DEPTH_C) &
                          (outstanding < DEPTH_C);
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Everything outstanding becomes stale on a redirect, less the word that
  // arrives in the redirect cycle itself (dropped immediately).
  always_comb begin
    kill_redirect = outstanding;
    if (imem_rsp_valid && (outstanding != '0)) begin
      kill_redirect = outstanding - CW'(1);
    end
    kill_next = kill_reg - CW'(do_drop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RST_WAIT;
      fetch_pc_reg <= RESET_PC;
      resp_pc_reg  <= RESET_PC;
      head_reg     <= '0;
      tail_reg     <= '0;
      occ_reg      <= '0;
      live_reg     <= '0;
      kill_reg     <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= redirect_aligned;
      resp_pc_reg  <= redirect_aligned;
      head_reg     <= '0;
      tail_reg     <= '0;
      occ_reg      <= '0;
      live_reg     <= '0;
      kill_reg     <= kill_redirect;
      state_reg    <= (kill_redirect != '0) ? DRAIN : FETCH;
    end else begin
      if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + STEP;
      end
      if (do_push) begin
        resp_pc_reg <= resp_pc_reg + STEP;
        tail_reg    <= (tail_reg == LAST_PTR) ? '0 : tail_reg + PW'(1);
      end
      if (do_pop) begin
        head_reg <= (head_reg == LAST_PTR) ? '0 : head_reg + PW'(1);
      end
      occ_reg  <= occ_reg + CW'(do_push) - CW'(do_pop);
      live_reg <= live_reg + CW'(req_fire) - CW'(do_push);
      kill_reg <= kill_next;

      case (state_reg)
        RST_WAIT: state_reg <= FETCH;
        FETCH:    state_reg <= FETCH;
        DRAIN:    if (kill_next == '0) state_reg <= FETCH;
        default:  state_reg <= FETCH;
      endcase
    end
  end

  // Buffer storage: written at the tail, read combinationally at the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      buf_pc[tail_reg]    <= resp_pc_reg;
      buf_instr[tail_reg] <= imem_rsp_data;
    end
  end

  // The credit check must make a push into a full, non-draining buffer impossible.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(do_push && !do_pop && (occ_reg == DEPTH_C)));
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        stall          = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (RESET_PC),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  // Model state: requests the memory holds, and words IF/ID should see.
  typedef struct { logic [31:0] addr; bit stale; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  mreq_t       mem_q[$];
  ent_t        mq[$];
  logic [31:0] exp_fetch = RESET_PC;
  int          edge_n = 0;
  int          max_lat = 1;
  int          vectors = 0;
  int          miscompares = 0;

  logic        cap_req_valid, cap_ready, cap_rsp, cap_redirect, cap_stall;
  logic [31:0] cap_addr, cap_redirect_pc;
  bit          push_it;
  ent_t        new_ent;
  mreq_t       r;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT head versus model head, every cycle.
  always @(negedge clk) begin
    cap_req_valid   = imem_req_valid;
    cap_ready       = imem_req_ready;
    cap_addr        = imem_req_addr;
    cap_rsp         = imem_rsp_valid;
    cap_redirect    = redirect_valid;
    cap_redirect_pc = redirect_pc;
    cap_stall       = stall;
    if (rst) begin
      check("rst_if_valid", {31'b0, if_valid}, 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_instr", if_instr, NOP);
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    end else begin
      if (mq.size() > 0) begin
        check("if_valid", {31'b0, if_valid}, 32'd1);
        check("if_pc", if_pc, mq[0].pc);
        check("if_instr", if_instr, mq[0].data);
      end else begin
        check("if_valid", {31'b0, if_valid}, 32'd0);
        check("if_pc", if_pc, 32'd0);
        check("if_instr", if_instr, NOP);
      end
      if (redirect_valid) check("req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
    end
  end

  // Model update at each edge, then the memory drives its next response.
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      mq.delete();
      mem_q.delete();
      exp_fetch = RESET_PC;
    end else begin
      push_it = 1'b0;
      if (cap_rsp && mem_q.size() > 0) begin
        r = mem_q.pop_front();
        if (!r.stale && !cap_redirect) begin
          push_it      = 1'b1;
          new_ent.pc   = r.addr;
          new_ent.data = word_of(r.addr);
        end
      end
      if (mq.size() > 0 && !cap_stall && !cap_redirect) void'(mq.pop_front());
      if (push_it) mq.push_back(new_ent);
      if (cap_redirect) begin
        mq.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        exp_fetch = {cap_redirect_pc[31:2], 2'b00};
      end
      if (cap_req_valid && cap_ready) begin
        check("req_addr", cap_addr, exp_fetch);
        r.addr  = cap_addr;
        r.stale = 1'b0;
        r.due   = edge_n + int'($urandom_range(max_lat, 1)) - 1;
        mem_q.push_back(r);
        exp_fetch = exp_fetch + 32'd4;
        check("outstanding_bound", 32'(mem_q.size() <= DEPTH), 32'd1);
      end
      check("buffer_bound", 32'(mq.size() <= DEPTH), 32'd1);
    end
    #1;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= edge_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_if_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_valid) break;
    end
  endtask

  logic [31:0] held_pc;

  initial begin
    // Reset and the one-cycle wait state.
    imem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_wait_if_instr", if_instr, 32'h0000_0013);
    cycle();
    @(negedge clk);
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0000_0000);

    // Sustained throughput: one instruction per cycle, PCs 0,4,8...
    wait_if_valid(10);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check("tput_valid", {31'b0, if_valid}, 32'd1);
      check("tput_pc", if_pc, 32'(4 * k));
      check("tput_instr", if_instr, word_of(32'(4 * k)));
    end
    cycle();

    // Stall with buffer full: head held, no requests.
    stall = 1'b1;
    @(negedge clk);
    held_pc = if_pc;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_pc_held", if_pc, held_pc);
      if (i >= 3) check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    end
    cycle();
    stall = 1'b0;
    repeat (6) cycle();

    // Two outstanding, redirect to 0x100.
    max_lat = 4;
    for (int i = 0; i < 30; i++) begin
      if (mem_q.size() == DEPTH) break;
      cycle();
    end
    check("two_outstanding", 32'(mem_q.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    wait_if_valid(40);
    check("redirect_seen", {31'b0, if_valid}, 32'd1);
    check("redirect_pc", if_pc, 32'h0000_0100);
    cycle();

    // Redirect coinciding with a live response and stall; unaligned target.
    max_lat = 2;
    for (int i = 0; i < 30; i++) begin
      if (imem_rsp_valid && mem_q.size() > 0 && !mem_q[0].stale) break;
      cycle();
    end
    check("rsp_for_redirect", {31'b0, imem_rsp_valid}, 32'd1);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0302;
    cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_rsp_if_valid", {31'b0, if_valid}, 32'd0);
    cycle();
    stall = 1'b0;
    wait_if_valid(30);
    check("redir_rsp_pc", if_pc, 32'h0000_0300);
    cycle();

    // Memory not ready: request held stable, nothing presented.
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    cycle();
    redirect_valid = 1'b0;
    repeat (6) cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("noready_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("noready_addr", imem_req_addr, 32'h0000_0200);
      check("noready_if_valid", {31'b0, if_valid}, 32'd0);
      check("noready_if_instr", if_instr, 32'h0000_0013);
    end
    cycle();
    imem_req_ready = 1'b1;

    // Randomized traffic.
    max_lat = 3;
    for (int n = 0; n < 1500; n++) begin
      imem_req_ready = ($urandom_range(99, 0) < 70);
      stall          = ($urandom_range(99, 0) < 25);
      redirect_valid = ($urandom_range(99, 0) < 4);
      redirect_pc    = $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    repeat (10) cycle();

    // Reset mid-stream with a full buffer.
    max_lat = 1;
    stall   = 1'b1;
    repeat (6) cycle();
    rst = 1'b1;
    #1;
    check("async_rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("async_rst_if_pc", if_pc, 32'd0);
    check("async_rst_if_instr", if_instr, 32'h0000_0013);
    check("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    stall = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) break;
    end
    check("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("post_rst_req_addr", imem_req_addr, RESET_PC);
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
